// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N:1 registered multiplexer with active-low gate, manual
// channel select and an auto-scan mode that dwells DWELL cycles per channel.
// Optional build macro: MUX_NX1_SCAN_PARITY_EN adds output PAR, the registered
// even parity of Y (0 whenever VALID is 0).
module mux_nx1_scan #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RSTbar,
    input  logic                      Gbar,
    input  logic                      MODE,
    input  logic [SEL_W-1:0]          SEL,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          CH,
`ifdef MUX_NX1_SCAN_PARITY_EN
    output logic                      PAR,
`endif
    output logic                      VALID
);

    localparam int                DW_W          = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]    LP_CHANNELS   = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0]  LP_LAST_CH    = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]   LP_LAST_DWELL = DW_W'(DWELL - 1);

    logic [SEL_W-1:0] r_ptr;
    logic [DW_W-1:0]  r_dwell;

    logic             w_sel_legal;
    logic             w_step;
    logic [SEL_W-1:0] w_src;
    logic [WIDTH-1:0] w_ch_data;
    logic [WIDTH-1:0] w_y_next;
    logic             w_valid_next;
    logic [SEL_W-1:0] w_ch_next;
    logic [SEL_W-1:0] w_ptr_next;
    logic [DW_W-1:0]  w_dwell_next;

    // Decode select legality, the dwell-step condition and the data mux.
    // Unmatched (illegal) indices leave the mux output at zero.
    always_comb begin
        w_sel_legal = ({1'b0, SEL} < LP_CHANNELS);
        w_step      = (r_dwell == LP_LAST_DWELL);
        w_src       = MODE ? r_ptr : SEL;
        w_ch_data   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (w_src == SEL_W'(k)) begin
                w_ch_data = D[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: gate freezes scan state, manual tracks SEL, auto-scan
    // walks the pointer with a dwell counter (dwell == DWELL-1 is the step state).
    always_comb begin
        w_y_next     = '0;
        w_valid_next = 1'b0;
        w_ch_next    = CH;
        w_ptr_next   = r_ptr;
        w_dwell_next = r_dwell;
        if (!Gbar) begin
            if (MODE) begin
                w_y_next     = w_ch_data;
                w_valid_next = 1'b1;
                w_ch_next    = r_ptr;
                if (w_step) begin
                    w_dwell_next = '0;
                    w_ptr_next   = (r_ptr == LP_LAST_CH) ? '0 : r_ptr + 1'b1;
                end else begin
                    w_dwell_next = r_dwell + 1'b1;
                end
            end else begin
                w_ch_next    = SEL;
                w_dwell_next = '0;
                w_ptr_next   = w_sel_legal ? SEL : '0;
                if (w_sel_legal) begin
                    w_y_next     = w_ch_data;
                    w_valid_next = 1'b1;
                end
            end
        end
    end

    // Register outputs and scan state; asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            Y       <= '0;
            CH      <= '0;
            VALID   <= 1'b0;
            r_ptr   <= '0;
            r_dwell <= '0;
        end else begin
            Y       <= w_y_next;
            CH      <= w_ch_next;
            VALID   <= w_valid_next;
            r_ptr   <= w_ptr_next;
            r_dwell <= w_dwell_next;
        end
    end

`ifdef MUX_NX1_SCAN_PARITY_EN
    // Parity of the next Y; it is zero whenever the next VALID is 0 because Y is.
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            PAR <= 1'b0;
        end else begin
            PAR <= ^w_y_next;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: drives two instances (8-bit x 4 ch, DWELL=4 and
// 8-bit x 3 ch, DWELL=1) from shared inputs and checks them against a
// behavioural model based on elapsed scan time.
module tb_mux_nx1_scan;

    logic        CLK = 1'b0;
    logic        RSTbar;
    logic        Gbar;
    logic        MODE;
    logic [1:0]  SEL;
    logic [31:0] D;

    logic [7:0]  y4, y3;
    logic [1:0]  ch4, ch3;
    logic        v4, v3;
`ifdef MUX_NX1_SCAN_PARITY_EN
    logic        par4, par3;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state per instance (0: 4 channels, 1: 3 channels)
    logic [7:0] m_y[2];
    int         m_ch[2];
    bit         m_v[2];
    int         m_start[2];
    int         m_t[2];

    always #5 CLK = ~CLK;

    mux_nx1_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u_dut4 (
        .CLK(CLK), .RSTbar(RSTbar), .Gbar(Gbar), .MODE(MODE), .SEL(SEL),
        .D(D), .Y(y4), .CH(ch4),
`ifdef MUX_NX1_SCAN_PARITY_EN
        .PAR(par4),
`endif
        .VALID(v4)
    );

    mux_nx1_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_dut3 (
        .CLK(CLK), .RSTbar(RSTbar), .Gbar(Gbar), .MODE(MODE), .SEL(SEL),
        .D(D[23:0]), .Y(y3), .CH(ch3),
`ifdef MUX_NX1_SCAN_PARITY_EN
        .PAR(par3),
`endif
        .VALID(v3)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_y[k] = '0; m_ch[k] = 0; m_v[k] = 0; m_start[k] = 0; m_t[k] = 0;
        end
    endtask

    // Update the model from the inputs about to be sampled, then clock once.
    task automatic tick();
        int c, dw, ch;
        for (int k = 0; k < 2; k++) begin
            c  = (k == 0) ? 4 : 3;
            dw = (k == 0) ? 4 : 1;
            if (Gbar) begin
                m_y[k] = '0;
                m_v[k] = 0;
            end else if (!MODE) begin
                m_ch[k] = int'(SEL);
                m_t[k]  = 0;
                if (int'(SEL) < c) begin
                    m_y[k] = D[8*int'(SEL) +: 8]; m_v[k] = 1; m_start[k] = int'(SEL);
                end else begin
                    m_y[k] = '0; m_v[k] = 0; m_start[k] = 0;
                end
            end else begin
                ch = (m_start[k] + m_t[k] / dw) % c;
                m_y[k] = D[8*ch +: 8]; m_ch[k] = ch; m_v[k] = 1;
                m_t[k]++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTbar = 1'b0; Gbar = 1'b0; MODE = 1'b0; SEL = 2'd0; D = '1;
        model_reset();
        #1;
        checks++; if ({y4, ch4, v4} !== 11'd0) begin failures++; $display("FAIL reset_init dut4 got=%h exp=0", {y4, ch4, v4}); end
        checks++; if ({y3, ch3, v3} !== 11'd0) begin failures++; $display("FAIL reset_init dut3 got=%h exp=0", {y3, ch3, v3}); end
        #1 RSTbar = 1'b1;
        SEL = 2'd1;
        tick();
        checks++; if (y4 !== 8'hFF || ch4 !== 2'd1 || v4 !== 1'b1) begin failures++; $display("FAIL reset_pre y4/ch4/v4 got=%h/%0d/%b exp=ff/1/1", y4, ch4, v4); end
        // Mid-cycle async reset with all-ones data: outputs clear without a clock edge
        #2 RSTbar = 1'b0;
        model_reset();
        #1;
        checks++; if ({y4, ch4, v4} !== 11'd0) begin failures++; $display("FAIL reset_async dut4 got=%h exp=0", {y4, ch4, v4}); end
        checks++; if ({y3, ch3, v3} !== 11'd0) begin failures++; $display("FAIL reset_async dut3 got=%h exp=0", {y3, ch3, v3}); end
        #1 RSTbar = 1'b1;
    endtask

    task automatic test_manual();
        Gbar = 1'b0; MODE = 1'b0; SEL = 2'd2; D = 32'hDDCCBBAA;
        tick();
        checks++; if (y4 !== 8'hCC || ch4 !== 2'd2 || v4 !== 1'b1) begin failures++; $display("FAIL manual_sel2 y/ch/v got=%h/%0d/%b exp=cc/2/1", y4, ch4, v4); end
        checks++; if (y3 !== m_y[1] || ch3 !== 2'(m_ch[1]) || v3 !== m_v[1]) begin failures++; $display("FAIL manual_sel2_dut3 got=%h/%0d/%b exp=%h/%0d/%b", y3, ch3, v3, m_y[1], m_ch[1], m_v[1]); end
        Gbar = 1'b1;
        tick();
        checks++; if (y4 !== 8'h00 || ch4 !== 2'd2 || v4 !== 1'b0) begin failures++; $display("FAIL manual_gated y/ch/v got=%h/%0d/%b exp=00/2/0", y4, ch4, v4); end
        Gbar = 1'b0; SEL = 2'd0;
        tick();
        checks++; if (y4 !== 8'hAA || ch4 !== 2'd0 || v4 !== 1'b1) begin failures++; $display("FAIL manual_sel0 y/ch/v got=%h/%0d/%b exp=aa/0/1", y4, ch4, v4); end
    endtask

    task automatic test_auto();
        logic [7:0] exp_y;
        Gbar = 1'b0; MODE = 1'b0; SEL = 2'd3; D = 32'hDDCCBBAA;
        tick();
        MODE = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_y = (i < 4) ? 8'hDD : (i < 8) ? 8'hAA : 8'hBB;
            checks++; if (y4 !== exp_y || v4 !== 1'b1) begin failures++; $display("FAIL auto_seq[%0d] y/v got=%h/%b exp=%h/1", i, y4, v4, exp_y); end
        end
        // Two edges into channel 2, then gate for three cycles
        tick(); tick();
        Gbar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (y4 !== 8'h00 || v4 !== 1'b0 || ch4 !== 2'd2) begin failures++; $display("FAIL auto_gated[%0d] y/v/ch got=%h/%b/%0d exp=00/0/2", i, y4, v4, ch4); end
        end
        Gbar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_y = (i < 2) ? 8'hCC : 8'hDD;
            checks++; if (y4 !== exp_y || v4 !== 1'b1) begin failures++; $display("FAIL auto_resume[%0d] y/v got=%h/%b exp=%h/1", i, y4, v4, exp_y); end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] exp_y;
        Gbar = 1'b0; MODE = 1'b0; SEL = 2'd3; D = 32'hDDCCBBAA;
        tick();
        checks++; if (y3 !== 8'h00 || v3 !== 1'b0 || ch3 !== 2'd3) begin failures++; $display("FAIL illegal_sel y/v/ch got=%h/%b/%0d exp=00/0/3", y3, v3, ch3); end
        MODE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_y = (i == 1) ? 8'hBB : (i == 2) ? 8'hCC : 8'hAA;
            checks++; if (ch3 !== 2'(i % 3) || y3 !== exp_y || v3 !== 1'b1) begin failures++; $display("FAIL illegal_scan[%0d] ch/y/v got=%0d/%h/%b exp=%0d/%h/1", i, ch3, y3, v3, i % 3, exp_y); end
        end
    endtask

    task automatic test_reset_midscan();
        logic [7:0] exp_y;
        Gbar = 1'b0; MODE = 1'b0; SEL = 2'd2; D = 32'hDDCCBBAA;
        tick();
        MODE = 1'b1;
        tick();
        checks++; if (y4 !== 8'hCC || ch4 !== 2'd2) begin failures++; $display("FAIL midscan_pre y/ch got=%h/%0d exp=cc/2", y4, ch4); end
        #2 RSTbar = 1'b0;
        model_reset();
        #1;
        checks++; if ({y4, ch4, v4} !== 11'd0) begin failures++; $display("FAIL midscan_reset got=%h exp=0", {y4, ch4, v4}); end
        #1 RSTbar = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_y = (i < 4) ? 8'hAA : 8'hBB;
            checks++; if (y4 !== exp_y || ch4 !== ((i < 4) ? 2'd0 : 2'd1)) begin failures++; $display("FAIL midscan_restart[%0d] y/ch got=%h/%0d exp=%h", i, y4, ch4, exp_y); end
        end
    endtask

`ifdef MUX_NX1_SCAN_PARITY_EN
    task automatic test_parity();
        Gbar = 1'b0; MODE = 1'b0; SEL = 2'd0; D = 32'hDDCC0307;
        tick();
        checks++; if (par4 !== 1'b1) begin failures++; $display("FAIL parity_07 got=%b exp=1", par4); end
        SEL = 2'd1;
        tick();
        checks++; if (par4 !== 1'b0) begin failures++; $display("FAIL parity_03 got=%b exp=0", par4); end
        SEL = 2'd0; Gbar = 1'b1;
        tick();
        checks++; if (par4 !== 1'b0) begin failures++; $display("FAIL parity_gated got=%b exp=0", par4); end
        Gbar = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Gbar = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) MODE = ~MODE;
            SEL = 2'($urandom_range(0, 3));
            D   = $urandom;
            tick();
            checks++; if (y4 !== m_y[0] || ch4 !== 2'(m_ch[0]) || v4 !== m_v[0]) begin failures++; $display("FAIL rand_dut4[%0d] y/ch/v got=%h/%0d/%b exp=%h/%0d/%b", i, y4, ch4, v4, m_y[0], m_ch[0], m_v[0]); end
            checks++; if (y3 !== m_y[1] || ch3 !== 2'(m_ch[1]) || v3 !== m_v[1]) begin failures++; $display("FAIL rand_dut3[%0d] y/ch/v got=%h/%0d/%b exp=%h/%0d/%b", i, y3, ch3, v3, m_y[1], m_ch[1], m_v[1]); end
`ifdef MUX_NX1_SCAN_PARITY_EN
            checks++; if (par4 !== (m_v[0] & ^m_y[0]) || par3 !== (m_v[1] & ^m_y[1])) begin failures++; $display("FAIL rand_par[%0d] got=%b%b exp=%b%b", i, par4, par3, m_v[0] & ^m_y[0], m_v[1] & ^m_y[1]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_illegal();
        test_reset_midscan();
`ifdef MUX_NX1_SCAN_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
